ar_seq_ctrl: RTL and testbench

Sequencer for the AR MAC datapath in the ARIMA core. It holds the coefficient and order configuration and drives the datapath's 2-bit control code (00 run, 01 stall, 11 clear). It wraps the datapath in valid/ready streams, flushes the final result on request, and tracks warm-up and overflow status. It sits between the sample source and the AR datapath, and it feeds the downstream combiner.

---
 rtl/arima_pkg.sv | 17 +
 rtl/ar_cfg_regs.sv | 56 +++++
 rtl/ar_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_ar_seq_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arima_pkg.sv
// Shared types and control encodings for the ARIMA core sequencers.
package arima_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [1:0] CTRL_RUN   = 2'b00;
    localparam logic [1:0] CTRL_STALL = 2'b01;
    localparam logic [1:0] CTRL_INIT  = 2'b10;
    localparam logic [1:0] CTRL_CLEAR = 2'b11;

endpackage

// File: rtl/ar_cfg_regs.sv
// Coefficient bank and AR order register with address/range checking.
// Writes are only taken while the sequencer is idle; anything rejected pulses o_err.
module ar_cfg_regs
    import arima_pkg::*;
#(
    parameter int N     = 32,
    parameter int P_MAX = 10,
    localparam int AW   = $clog2(P_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_idle,
    input  logic [AW-1:0] i_addr,
    input  logic [N-1:0]  i_wdata,
    output logic [N-1:0]  o_coef [0:P_MAX-1],
    output logic [AW-1:0] o_p_order,
    output logic          o_err
);

    logic [N-1:0]  r_coef [0:P_MAX-1];
    logic [AW-1:0] r_p_order;
    logic          w_slot_sel;
    logic          w_ord_sel;
    logic          w_ord_ok;
    logic          w_accept;

    assign w_slot_sel = (i_addr < AW'(P_MAX));
    assign w_ord_sel  = (i_addr == AW'(P_MAX));
    // Order is unsigned 1..P_MAX-1; negative words compare as huge and are rejected.
    assign w_ord_ok   = (i_wdata != '0) && (i_wdata < N'(P_MAX));
    assign w_accept   = i_we && i_idle && (w_slot_sel || (w_ord_sel && w_ord_ok));
    assign o_err      = i_we && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < P_MAX; i++) begin
                r_coef[i] <= '0;
            end
            r_p_order <= '0;
        end else if (w_accept) begin
            if (w_ord_sel) begin
                r_p_order <= AW'(i_wdata);
            end
            for (int unsigned i = 0; i < P_MAX; i++) begin
                if (w_slot_sel && (i_addr == AW'(i))) begin
                    r_coef[i] <= i_wdata;
                end
            end
        end
    end

    assign o_coef    = r_coef;
    assign o_p_order = r_p_order;

endmodule

// File: rtl/ar_seq_ctrl.sv
// Sequencer for the AR MAC datapath: config bank, run/stall/clear control,
// valid/ready wrapping of the 2-advance-latency datapath, flush and status.
module ar_seq_ctrl
    import arima_pkg::*;
#(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int P_MAX = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(P_MAX+1)-1:0]   cfg_addr,
    input  logic [N-1:0]                 cfg_wdata,
    output logic                         cfg_err,
    input  logic                         start,
    input  logic                         flush,
    output logic                         busy,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N-1:0]                 s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [N-1:0]                 m_data,
    output logic                         m_warm,
    output logic [1:0]                   ar_control,
    output logic [N-1:0]                 ar_data_in,
    output logic [N-1:0]                 ar_coef [0:P_MAX-1],
    output logic [N-1:0]                 ar_p_order,
    input  logic [N-1:0]                 ar_data_out,
    input  logic                         ar_overflow,
    output logic                         ovf_sticky
);

    localparam int AW = $clog2(P_MAX + 1);

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("ar_seq_ctrl: Q must lie in 0..N-1");
    end

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_count;
    logic          r_m_valid;
    logic          r_m_warm;
    logic          r_cfg_err;
    logic          r_ovf;
    logic [AW-1:0] w_p_order;
    logic          w_cfg_wr_err;
    logic          w_drain_ok;
    logic          w_adv_run;
    logic          w_adv_flush;
    logic          w_adv;
    logic          w_start_ok;
    logic          w_start_bad;

    ar_cfg_regs #(
        .N     (N),
        .P_MAX (P_MAX)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .i_we      (cfg_we),
        .i_idle    (r_state == IDLE),
        .i_addr    (cfg_addr),
        .i_wdata   (cfg_wdata),
        .o_coef    (ar_coef),
        .o_p_order (w_p_order),
        .o_err     (w_cfg_wr_err)
    );

    assign w_drain_ok  = !r_m_valid || m_ready;
    assign w_adv_run   = (r_state == RUN) && s_valid && w_drain_ok;
    assign w_adv_flush = (r_state == FLUSH) && w_drain_ok;
    assign w_adv       = w_adv_run || w_adv_flush;
    assign w_start_ok  = (r_state == IDLE) && start && (w_p_order != '0);
    assign w_start_bad = (r_state == IDLE) && start && (w_p_order == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_next = CLEAR;
            CLEAR:   w_next = RUN;
            RUN:     if (flush) w_next = FLUSH;
            FLUSH:   if (w_drain_ok) w_next = DONE;
            DONE:    if (!r_m_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ar_control = CTRL_STALL;
        ar_data_in = '0;
        s_ready    = (r_state == RUN) && w_drain_ok;
        busy       = (r_state != IDLE);
        if (rst || (r_state == CLEAR)) begin
            ar_control = CTRL_CLEAR;
        end else if (w_adv) begin
            ar_control = CTRL_RUN;
        end
        if (w_adv_run) begin
            ar_data_in = s_data;
        end
    end

    // The first advance only primes the pipeline; each later one (and the flush
    // advance) pushes a finished result out, so emission keys off count>=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_m_warm  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count   <= '0;
                r_cfg_err <= 1'b0;
                r_ovf     <= 1'b0;
            end
            if (w_adv_run && (r_count != AW'(P_MAX))) begin
                r_count <= r_count + AW'(1);
            end
            if (w_adv && (r_count != '0)) begin
                r_m_valid <= 1'b1;
                r_m_warm  <= (r_count < w_p_order);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
                r_m_warm  <= 1'b0;
            end
            if (w_adv && ar_overflow) begin
                r_ovf <= 1'b1;
            end
            if (w_cfg_wr_err || w_start_bad) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign m_valid    = r_m_valid;
    assign m_warm     = r_m_warm;
    assign m_data     = ar_data_out;
    assign cfg_err    = r_cfg_err;
    assign ovf_sticky = r_ovf;
    assign ar_p_order = N'(w_p_order);

endmodule

// File: tb/tb_ar_seq_ctrl.sv
// Directed bench for ar_seq_ctrl with a behavioural AR datapath (2-advance latency).
module tb_ar_seq_ctrl;

    localparam int N     = 32;
    localparam int Q     = 15;
    localparam int P_MAX = 10;
    localparam int AW    = $clog2(P_MAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [N-1:0]  cfg_wdata;
    logic          cfg_err;
    logic          start;
    logic          flush;
    logic          busy;
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_data;
    logic          m_warm;
    logic [1:0]    ar_control;
    logic [N-1:0]  ar_data_in;
    logic [N-1:0]  ar_coef [0:P_MAX-1];
    logic [N-1:0]  ar_p_order;
    logic [N-1:0]  ar_data_out;
    logic          ar_overflow;
    logic          ovf_sticky;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] got_d [$];
    logic         got_w [$];
    logic [N-1:0] hist [0:P_MAX-1];

    ar_seq_ctrl #(
        .N     (N),
        .Q     (Q),
        .P_MAX (P_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_err     (cfg_err),
        .start       (start),
        .flush       (flush),
        .busy        (busy),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_warm      (m_warm),
        .ar_control  (ar_control),
        .ar_data_in  (ar_data_in),
        .ar_coef     (ar_coef),
        .ar_p_order  (ar_p_order),
        .ar_data_out (ar_data_out),
        .ar_overflow (ar_overflow),
        .ovf_sticky  (ovf_sticky)
    );

    always #5 clk = ~clk;

    // y_k = sum c_i * x_{k-i} >> Q, presented after the advance that takes x_{k+1}.
    function automatic logic [N-1:0] fir_val();
        longint acc = 0;
        for (int i = 0; i < P_MAX; i++) begin
            if (i < int'(ar_p_order)) begin
                acc += longint'($signed(ar_coef[i])) * longint'($signed(hist[i]));
            end
        end
        return N'(acc >>> Q);
    endfunction

    always @(posedge clk) begin
        if (ar_control == 2'b11) begin
            for (int i = 0; i < P_MAX; i++) hist[i] <= '0;
            ar_data_out <= '0;
        end else if (ar_control == 2'b00) begin
            ar_data_out <= fir_val();
            hist[0] <= ar_data_in;
            for (int i = 1; i < P_MAX; i++) hist[i] <= hist[i-1];
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_w.push_back(m_warm);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout busy=%b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        total++;
        if (ar_control !== 2'b11) begin
            bad++; $display("FAIL reset_ctrl got=%b want=11", ar_control);
        end
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_warm !== 1'b0 || cfg_err !== 1'b0 ||
            ovf_sticky !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b mv=%b mw=%b err=%b ovf=%b srdy=%b want all 0",
                     busy, m_valid, m_warm, cfg_err, ovf_sticky, s_ready);
        end
        total++;
        if (ar_control !== 2'b01 || ar_p_order !== '0 || ar_coef[0] !== '0 || ar_coef[P_MAX-1] !== '0) begin
            bad++;
            $display("FAIL reset_cfg ctrl=%b ord=%0d c0=%0d c9=%0d want 01/0/0/0",
                     ar_control, ar_p_order, ar_coef[0], ar_coef[P_MAX-1]);
        end
    endtask

    task automatic test_stream();
        logic [N-1:0] xs [3];
        logic [N-1:0] ed [3];
        logic         ew [3];
        xs = '{32'd32768, 32'd65536, 32'd0};
        ed = '{32'd16384, 32'd40960, 32'd16384};
        ew = '{1'b1, 1'b0, 1'b0};
        got_d.delete(); got_w.delete();
        cfg_write(AW'(P_MAX), 32'd2);
        cfg_write(AW'(0), 32'd16384);
        cfg_write(AW'(1), 32'd8192);
        total++;
        if (ar_p_order !== 32'd2 || ar_coef[0] !== 32'd16384 || ar_coef[1] !== 32'd8192 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL stream_cfg ord=%0d c0=%0d c1=%0d err=%b want 2/16384/8192/0",
                     ar_p_order, ar_coef[0], ar_coef[1], cfg_err);
        end
        m_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total++;
        if (ar_control !== 2'b11 || busy !== 1'b1 || s_ready !== 1'b0) begin
            bad++; $display("FAIL stream_clear ctrl=%b busy=%b srdy=%b want 11/1/0", ar_control, busy, s_ready);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = xs[i];
            #1;
            total++;
            if (s_ready !== 1'b1 || ar_control !== 2'b00 || ar_data_in !== xs[i]) begin
                bad++;
                $display("FAIL stream_adv%0d srdy=%b ctrl=%b din=%0d want 1/00/%0d",
                         i, s_ready, ar_control, ar_data_in, xs[i]);
            end
            cyc();
        end
        s_valid = 1'b0; s_data = '0;
        total++;
        if (m_valid !== 1'b1 || m_data !== 32'd40960 || m_warm !== 1'b0) begin
            bad++; $display("FAIL stream_second mv=%b data=%0d warm=%b want 1/40960/0", m_valid, m_data, m_warm);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        total++;
        if (ar_control !== 2'b00 || ar_data_in !== '0) begin
            bad++; $display("FAIL stream_flush_adv ctrl=%b din=%0d want 00/0", ar_control, ar_data_in);
        end
        wait_idle("stream");
        total++;
        if (got_d.size() != 3) begin
            bad++; $display("FAIL stream_count got=%0d want=3", got_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (got_d[i] !== ed[i] || got_w[i] !== ew[i]) begin
                    bad++;
                    $display("FAIL stream_res%0d data=%0d warm=%b want %0d/%b", i, got_d[i], got_w[i], ed[i], ew[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] ed [3];
        logic         ew [3];
        ed = '{32'd16384, 32'd40960, 32'd16384};
        ew = '{1'b1, 1'b0, 1'b0};
        got_d.delete(); got_w.delete();
        m_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        s_valid = 1'b1; s_data = 32'd32768; cyc();
        s_data = 32'd65536; cyc();
        m_ready = 1'b0; s_data = 32'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (s_ready !== 1'b0 || ar_control !== 2'b01 || m_valid !== 1'b1 || m_data !== 32'd16384) begin
                bad++;
                $display("FAIL stall_hold%0d srdy=%b ctrl=%b mv=%b data=%0d want 0/01/1/16384",
                         i, s_ready, ar_control, m_valid, m_data);
            end
            cyc();
        end
        m_ready = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1 || ar_control !== 2'b00) begin
            bad++; $display("FAIL stall_release srdy=%b ctrl=%b want 1/00", s_ready, ar_control);
        end
        cyc();
        s_valid = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;
        wait_idle("stall");
        total++;
        if (got_d.size() != 3) begin
            bad++; $display("FAIL stall_count got=%0d want=3", got_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (got_d[i] !== ed[i] || got_w[i] !== ew[i]) begin
                    bad++;
                    $display("FAIL stall_res%0d data=%0d warm=%b want %0d/%b", i, got_d[i], got_w[i], ed[i], ew[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] xs [3];
        xs = '{32'd32768, 32'd65536, 32'd0};
        m_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = xs[i]; ar_overflow = (i == 1);
            cyc();
            total++;
            if (ovf_sticky !== (i >= 1)) begin
                bad++; $display("FAIL ovf_adv%0d got=%b want=%b", i, ovf_sticky, (i >= 1));
            end
        end
        s_valid = 1'b0; ar_overflow = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;
        wait_idle("ovf");
        total++;
        if (ovf_sticky !== 1'b1) begin
            bad++; $display("FAIL ovf_held got=%b want=1", ovf_sticky);
        end
        start = 1'b1; cyc(); start = 1'b0;
        total++;
        if (ovf_sticky !== 1'b0) begin
            bad++; $display("FAIL ovf_restart got=%b want=0", ovf_sticky);
        end
        cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        wait_idle("ovf2");
    endtask

    task automatic test_midrun_reset();
        got_d.delete(); got_w.delete();
        m_ready = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        s_valid = 1'b1; s_data = 32'd32768; cyc();
        s_data = 32'd65536; cyc();
        s_valid = 1'b0; s_data = '0;
        total++;
        if (m_valid !== 1'b1) begin
            bad++; $display("FAIL rstrun_pre mv=%b want=1", m_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (ar_control !== 2'b11) begin
            bad++; $display("FAIL rstrun_ctrl_in_reset got=%b want=11", ar_control);
        end
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || ar_control !== 2'b01 ||
            ar_coef[0] !== '0 || ar_coef[1] !== '0 || ar_p_order !== '0 || got_d.size() != 0) begin
            bad++;
            $display("FAIL rstrun_after mv=%b busy=%b ctrl=%b c0=%0d c1=%0d ord=%0d outs=%0d want 0/0/01/0/0/0/0",
                     m_valid, busy, ar_control, ar_coef[0], ar_coef[1], ar_p_order, got_d.size());
        end
        m_ready = 1'b1;
    endtask

    task automatic test_cfg_err();
        cfg_write(AW'(P_MAX), 32'd0);
        total++;
        if (cfg_err !== 1'b1 || ar_p_order !== '0) begin
            bad++; $display("FAIL cfgerr_zero err=%b ord=%0d want 1/0", cfg_err, ar_p_order);
        end
        cfg_write(AW'(P_MAX), 32'd10);
        total++;
        if (cfg_err !== 1'b1 || ar_p_order !== '0) begin
            bad++; $display("FAIL cfgerr_pmax err=%b ord=%0d want 1/0", cfg_err, ar_p_order);
        end
        start = 1'b1; cyc(); start = 1'b0;
        total++;
        if (busy !== 1'b0 || cfg_err !== 1'b1) begin
            bad++; $display("FAIL cfgerr_badstart busy=%b err=%b want 0/1", busy, cfg_err);
        end
        cfg_write(AW'(P_MAX), 32'd3);
        total++;
        if (ar_p_order !== 32'd3 || cfg_err !== 1'b1) begin
            bad++; $display("FAIL cfgerr_goodord ord=%0d err=%b want 3/1", ar_p_order, cfg_err);
        end
        start = 1'b1; cyc(); start = 1'b0;
        total++;
        if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            bad++; $display("FAIL cfgerr_start_clears busy=%b err=%b want 1/0", busy, cfg_err);
        end
        cyc();
        cfg_write(AW'(0), 32'd123);
        total++;
        if (cfg_err !== 1'b1 || ar_coef[0] !== '0) begin
            bad++; $display("FAIL cfgerr_run_write err=%b c0=%0d want 1/0", cfg_err, ar_coef[0]);
        end
        flush = 1'b1; cyc(); flush = 1'b0;
        wait_idle("cfgerr");
    endtask

    task automatic test_start_flush();
        got_d.delete(); got_w.delete();
        cfg_write(AW'(P_MAX), 32'd2);
        cfg_write(AW'(0), 32'd16384);
        cfg_write(AW'(1), 32'd8192);
        m_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        flush = 1'b1;
        #1;
        total++;
        if (ar_control !== 2'b11 || busy !== 1'b1) begin
            bad++; $display("FAIL sf_clear ctrl=%b busy=%b want 11/1", ar_control, busy);
        end
        cyc();
        total++;
        if (ar_control !== 2'b01 || s_ready !== 1'b1) begin
            bad++; $display("FAIL sf_run ctrl=%b srdy=%b want 01/1", ar_control, s_ready);
        end
        cyc();
        flush = 1'b0;
        #1;
        total++;
        if (ar_control !== 2'b00 || ar_data_in !== '0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL sf_flush_adv ctrl=%b din=%0d srdy=%b want 00/0/0", ar_control, ar_data_in, s_ready);
        end
        cyc();
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL sf_done mv=%b busy=%b want 0/1", m_valid, busy);
        end
        cyc();
        total++;
        if (busy !== 1'b0 || got_d.size() != 0) begin
            bad++; $display("FAIL sf_idle busy=%b outs=%0d want 0/0", busy, got_d.size());
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b1; ar_overflow = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_overflow();
        test_midrun_reset();
        test_cfg_err();
        test_start_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
